vga_sync: RTL

Generates 640x480 @ 60 Hz VGA timing from the 100 MHz board clock. It produces the pixel-enable strobe, the current pixel coordinates `x`/`y`, the active-low sync pulses, and a display-active flag. It is the first stage of the video pipeline: every `draw_*` layer consumes its `x`/`y` combinationally, and the final colour mux gates its RGB output with `video_on`.

---
 rtl/vga_sync_pkg.sv | 24 ++
 rtl/pixel_tick_gen.sv | 21 ++
 rtl/vga_sync.sv | 78 +++++++
 3 files changed

// File: rtl/vga_sync_pkg.sv
// Shared VGA timing defaults and coordinate helpers, imported by vga_sync and
// by the draw_* layers for screen-bound comparisons.
package vga_sync_pkg;
  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int TICK_DIV_DEF  = 4;

  localparam int H_TOTAL_DEF = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // Inclusive window test, used for the sync pulse regions.
  function automatic logic in_window(input coord_t v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction
endpackage

// File: rtl/pixel_tick_gen.sv
// Mod-TICK_DIV counter; p_tick is high for the last cycle of each period.
module pixel_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);
  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] div_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                div_cnt <= '0;
    else if (div_cnt == LAST) div_cnt <= '0;
    else                      div_cnt <= div_cnt + W'(1);
  end

  assign p_tick = (div_cnt == LAST);
endmodule

// File: rtl/vga_sync.sv
// VGA timing generator: pixel strobe, x/y counters, registered active-low syncs,
// display-active flag and a one-cycle frame wrap pulse.
module vga_sync
  import vga_sync_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter int TICK_DIV  = TICK_DIV_DEF
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_tick
);
  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  localparam coord_t X_MAX = coord_t'(H_TOTAL - 1);
  localparam coord_t Y_MAX = coord_t'(V_TOTAL - 1);

  coord_t x_next, y_next;
  logic   line_end;

  pixel_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  assign line_end = p_tick && (x == X_MAX);

  always_comb begin
    x_next = x;
    y_next = y;
    if (p_tick) begin
      if (x == X_MAX) begin
        x_next = '0;
        y_next = (y == Y_MAX) ? '0 : y + coord_t'(1);
      end else begin
        x_next = x + coord_t'(1);
      end
    end
  end

  // Syncs are computed from the next-state counters so they line up with x/y.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x          <= '0;
      y          <= '0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      x          <= x_next;
      y          <= y_next;
      hsync      <= !in_window(x_next, HS_START, HS_END);
      vsync      <= !in_window(y_next, VS_START, VS_END);
      frame_tick <= line_end && (y == Y_MAX);
    end
  end

  assign video_on = (x < coord_t'(H_DISPLAY)) && (y < coord_t'(V_DISPLAY));
endmodule
